// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Two-master, one-slave arbiter for the Bridge data bus. Master 0 is the CPU
// load/store port, master 1 is a secondary master (DMA or debug loader).
// Ownership is registered and held by the current owner while it keeps
// requesting. A hold counter limits a tenure to MAX_HOLD cycles while the
// other master waits. Simultaneous requests from IDLE are broken round-robin.
//
// Ports:
//   cpu_clk, cpu_rst       clock (rising edge), async active-low reset
//   mX_req/addr/we/wdata   master X request, address, write enable, write data
//   mX_gnt                 master X owns the bus (decoded from registered state)
//   mX_ack                 master X transfer completes this cycle
//   mX_rdata               broadcast copy of Bus_rdata, valid when mX_ack
//   Bus_addr/we/wdata      slave side, muxed from the current owner
//   Bus_rdata              slave read data, combinational
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] Bus_addr,
  output logic              Bus_we,
  output logic [DATA_W-1:0] Bus_wdata,
  input  logic [DATA_W-1:0] Bus_rdata
);

  // A one-bit counter is still kept when MAX_HOLD is 1 so the width is legal.
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             lastOwner_q, lastOwner_d;
  logic [CNT_W-1:0] holdCnt_q, holdCnt_d;

  // Next-state logic. The hold counter only advances while the other master
  // is waiting; reaching HOLD_LAST with both requesting forces a hand-over,
  // so the counter never needs an explicit saturation check beyond that.
  // Entering an OWN state always clears the counter and records the owner.
  always_comb begin
    state_d     = state_q;
    lastOwner_d = lastOwner_q;
    holdCnt_d   = holdCnt_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) state_d = lastOwner_q ? OWN0 : OWN1;
        else if (m0_req)      state_d = OWN0;
        else if (m1_req)      state_d = OWN1;
      end
      OWN0: begin
        if (!m0_req) begin
          state_d = m1_req ? OWN1 : IDLE;
        end else if (m1_req) begin
          if (holdCnt_q == HOLD_LAST) state_d = OWN1;
          else                        holdCnt_d = holdCnt_q + 1'b1;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          state_d = m0_req ? OWN0 : IDLE;
        end else if (m0_req) begin
          if (holdCnt_q == HOLD_LAST) state_d = OWN0;
          else                        holdCnt_d = holdCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == OWN0 && state_q != OWN0) begin
      holdCnt_d   = '0;
      lastOwner_d = 1'b0;
    end else if (state_d == OWN1 && state_q != OWN1) begin
      holdCnt_d   = '0;
      lastOwner_d = 1'b1;
    end
  end

  // State register. lastOwner resets to 1 so master 0 wins the first tie.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q     <= IDLE;
      lastOwner_q <= 1'b1;
      holdCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lastOwner_q <= lastOwner_d;
      holdCnt_q   <= holdCnt_d;
    end
  end

  // Grants come straight from the registered state, so an asynchronous reset
  // clears grant, ack and the write strobe without waiting for a clock edge.
  assign m0_gnt   = (state_q == OWN0);
  assign m1_gnt   = (state_q == OWN1);
  assign m0_ack   = m0_gnt & m0_req;
  assign m1_ack   = m1_gnt & m1_req;
  assign m0_rdata = Bus_rdata;
  assign m1_rdata = Bus_rdata;

  // Slave mux. Only the owner's fields reach the bus, and the strobe is
  // qualified by the owner's own request so a dropped request never writes.
  always_comb begin
    Bus_addr  = '0;
    Bus_wdata = '0;
    Bus_we    = 1'b0;
    if (state_q == OWN0) begin
      Bus_addr  = m0_addr;
      Bus_wdata = m0_wdata;
      Bus_we    = m0_we & m0_req;
    end else if (state_q == OWN1) begin
      Bus_addr  = m1_addr;
      Bus_wdata = m1_wdata;
      Bus_we    = m1_we & m1_req;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed self-checking bench for bus_arbiter with MAX_HOLD=4. Inputs are
// driven 1 ns after each rising edge and outputs sampled there as well.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  logic        cpu_clk;
  logic        cpu_rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
  logic        Bus_we;

  int compareCount  = 0;
  int mismatchCount = 0;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rst  (cpu_rst),
    .m0_req   (m0_req),
    .m0_addr  (m0_addr),
    .m0_we    (m0_we),
    .m0_wdata (m0_wdata),
    .m0_gnt   (m0_gnt),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_addr  (m1_addr),
    .m1_we    (m1_we),
    .m1_wdata (m1_wdata),
    .m1_gnt   (m1_gnt),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .Bus_addr (Bus_addr),
    .Bus_we   (Bus_we),
    .Bus_wdata(Bus_wdata),
    .Bus_rdata(Bus_rdata)
  );

  // Free-running 10 ns clock
  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one master's request fields
  task automatic applyStimulus(input int m, input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick;
    @(posedge cpu_clk);
    #1;
  endtask

  // Directed sequence
  initial begin
    int owner;
    cpu_rst   = 1'b0;
    Bus_rdata = 32'h0;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    tick; tick;
    checkOutput("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    checkOutput("rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    checkOutput("rst_m0_ack", {31'b0, m0_ack}, 32'd0);
    checkOutput("rst_m1_ack", {31'b0, m1_ack}, 32'd0);
    checkOutput("rst_bus_we", {31'b0, Bus_we}, 32'd0);
    checkOutput("rst_bus_addr", Bus_addr, 32'd0);
    checkOutput("rst_bus_wdata", Bus_wdata, 32'd0);
    cpu_rst = 1'b1;
    tick;

    // m0 write from IDLE: granted and acked on the next cycle
    applyStimulus(0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
    #1;
    checkOutput("t1_pre_m0_ack", {31'b0, m0_ack}, 32'd0);
    tick;
    checkOutput("t1_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    checkOutput("t1_m0_ack", {31'b0, m0_ack}, 32'd1);
    checkOutput("t1_bus_we", {31'b0, Bus_we}, 32'd1);
    checkOutput("t1_bus_addr", Bus_addr, 32'h100);
    checkOutput("t1_bus_wdata", Bus_wdata, 32'hDEADBEEF);
    checkOutput("t1_m1_gnt", {31'b0, m1_gnt}, 32'd0);

    // m0 drops with m1 idle: back to IDLE, bus cleared
    applyStimulus(0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
    tick;
    checkOutput("t5a_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    checkOutput("t5a_bus_we", {31'b0, Bus_we}, 32'd0);
    checkOutput("t5a_bus_addr", Bus_addr, 32'd0);

    // m1 read with broadcast read data
    applyStimulus(1, 1'b1, 1'b0, 32'h80, 32'h0);
    Bus_rdata = 32'h12345678;
    tick;
    checkOutput("t4_m1_ack", {31'b0, m1_ack}, 32'd1);
    checkOutput("t4_m1_rdata", m1_rdata, 32'h12345678);
    checkOutput("t4_m0_ack", {31'b0, m0_ack}, 32'd0);
    checkOutput("t4_bus_we", {31'b0, Bus_we}, 32'd0);
    checkOutput("t4_bus_addr", Bus_addr, 32'h80);
    applyStimulus(1, 1'b0, 1'b0, 32'h80, 32'h0);
    tick;
    checkOutput("t4_idle_m1_gnt", {31'b0, m1_gnt}, 32'd0);

    // Both request together from IDLE (last owner m1): 4/4/4 alternation,
    // m0 writes, m1 reads so the strobe follows the owner only
    applyStimulus(0, 1'b1, 1'b1, 32'h300, 32'hA0A0A0A0);
    applyStimulus(1, 1'b1, 1'b0, 32'h200, 32'h0B0B0B0B);
    for (int c = 0; c < 12; c++) begin
      tick;
      owner = (c / 4) % 2;
      checkOutput($sformatf("t2_c%0d_m0_ack", c), {31'b0, m0_ack}, (owner == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t2_c%0d_m1_ack", c), {31'b0, m1_ack}, (owner == 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t2_c%0d_bus_we", c), {31'b0, Bus_we}, (owner == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t2_c%0d_bus_addr", c), Bus_addr, (owner == 0) ? 32'h300 : 32'h200);
    end

    // Owner m0 (counter at its limit) drops with m1 also dropping: IDLE
    applyStimulus(0, 1'b0, 1'b1, 32'h300, 32'hA0A0A0A0);
    applyStimulus(1, 1'b0, 1'b0, 32'h200, 32'h0B0B0B0B);
    tick;
    checkOutput("t5b_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    checkOutput("t5b_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    checkOutput("t5b_bus_we", {31'b0, Bus_we}, 32'd0);

    // Simultaneous request after m0's tenure goes to m1; m1 writes
    applyStimulus(0, 1'b1, 1'b0, 32'h500, 32'h0);
    applyStimulus(1, 1'b1, 1'b1, 32'h400, 32'h55AA55AA);
    tick;
    checkOutput("t5c_m1_gnt", {31'b0, m1_gnt}, 32'd1);
    checkOutput("t5c_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    checkOutput("t5c_bus_we", {31'b0, Bus_we}, 32'd1);
    checkOutput("t5c_bus_wdata", Bus_wdata, 32'h55AA55AA);

    // Asynchronous reset mid-cycle during m1's write
    #2 cpu_rst = 1'b0;
    #1;
    checkOutput("t6_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    checkOutput("t6_m1_ack", {31'b0, m1_ack}, 32'd0);
    checkOutput("t6_bus_we", {31'b0, Bus_we}, 32'd0);
    tick; tick;
    #3 cpu_rst = 1'b1;
    tick;
    checkOutput("t6_post_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    checkOutput("t6_post_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    checkOutput("t6_post_bus_addr", Bus_addr, 32'h500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter in front of the Bridge data bus.
- Master 0 is the CPU load/store port; master 1 is a secondary master (DMA or debug loader).
- Grants are registered and owner-held, with round-robin tie-break.
- A hold counter bounds how long one master can keep the bus while the other waits.
- The slave sees one master's address, write-enable and write-data at a time; read data is broadcast and qualified per master by ack.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_HOLD, 4, maximum consecutive owned cycles while the other master is requesting; legal range is 1 or more.

Ports:
- cpu_clk  in  1  clock, rising edge.
- cpu_rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 transfer request; held until acked.
- m0_addr  in  ADDR_W  master 0 address.
- m0_we  in  1  master 0 write (1) or read (0).
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 currently owns the bus.
- m0_ack  out  1  master 0 transfer completes this cycle.
- m0_rdata  out  DATA_W  read data to master 0.
- m1_req, m1_addr, m1_we, m1_wdata, m1_gnt, m1_ack, m1_rdata: same as master 0, for master 1.
- Bus_addr  out  ADDR_W  slave address.
- Bus_we  out  1  slave write strobe.
- Bus_wdata  out  DATA_W  slave write data.
- Bus_rdata  in  DATA_W  slave read data; combinational, valid in the same cycle as the address.

Behaviour:
- Reset (cpu_rst=0, asynchronous):
  - state=IDLE, last_owner=1 (so master 0 wins the first tie), hold_cnt=0.
  - m0_gnt=m1_gnt=0, m0_ack=m1_ack=0, Bus_we=0, Bus_addr=0, Bus_wdata=0.
  - Reset release is synchronous to cpu_clk.
- States are IDLE, OWN0 and OWN1. All transitions occur on the rising edge of cpu_clk.
- IDLE:
  - req0 and req1 both high: go to OWN(~last_owner).
  - Only req0 high: go to OWN0.
  - Only req1 high: go to OWN1.
  - Neither: stay in IDLE.
- OWNx:
  - reqx low and other req high: go to OWN(other).
  - reqx low and other req low: go to IDLE.
  - reqx high, other req high, hold_cnt==MAX_HOLD-1: go to OWN(other).
  - Otherwise: stay in OWNx; hold_cnt increments, saturating at MAX_HOLD-1.
- On entry to OWNx: hold_cnt=0 and last_owner=x.
- hold_cnt only advances while the other master is requesting; otherwise it holds its value.
- Outputs:
  - mx_gnt = (state==OWNx), decoded directly from the registered state.
  - mx_ack = mx_gnt & mx_req.
  - m0_rdata = m1_rdata = Bus_rdata (broadcast); each master uses it only when its ack is high.
- Slave mux:
  - In OWNx: Bus_addr=mx_addr, Bus_wdata=mx_wdata, Bus_we=mx_we & mx_req.
  - In IDLE: all three are 0.
- Latency:
  - A request raised in IDLE is granted the next cycle and acked that same cycle.
  - A back-to-back request from the owner is acked every cycle.
  - Worst-case wait for a competing master is MAX_HOLD+1 cycles after its req rises.
- An owner deasserting req for one cycle loses ownership; it re-arbitrates from IDLE or waits for the other master's tenure.
- Masters must hold addr, we and wdata stable while req is high and ack is low; the arbiter does not latch them.
- With MAX_HOLD=1 and both masters requesting continuously, ownership alternates every cycle.
- A write strobe is never issued in IDLE, and never for a non-owner, including the switch cycle.
- Reset asserted mid-transfer: gnt, ack and Bus_we go to 0 immediately; after release, arbitration restarts with master 0 priority.

Test Plan:
- Reset, then m0_req=1 with a write to addr 0x100, data 0xDEADBEEF. Required: next cycle m0_gnt=m0_ack=1, Bus_we=1, Bus_addr=0x100, Bus_wdata=0xDEADBEEF; m1_gnt=0 throughout.
- From IDLE, m0_req and m1_req rise in the same cycle. Required: OWN0 first; with MAX_HOLD=4, m0_ack is high for exactly 4 cycles, then OWN1 begins.
- Continue the previous test with both masters requesting. Required: m1 holds for 4 cycles, then returns to m0; the pattern is 4/4 alternating, and Bus_we is never high for the non-owner.
- m1 reads with Bus_rdata driven to 0x12345678. Required: m1_ack=1 and m1_rdata=0x12345678 in the same cycle; m0_ack=0.
- Owner m0 drops req while m1 is idle. Required: IDLE on the next cycle with Bus_we=0 and Bus_addr=0. A later simultaneous request goes to m1 (round-robin, since last_owner=0).
- With OWN1 active and a write in progress, assert cpu_rst=0 asynchronously mid-cycle. Required: gnt, ack and Bus_we are 0 before the next clock edge. After release with both masters requesting, m0 is granted first.
